// File: rtl/rx_uart_ctrl.sv
// UART receive-path controller: bus register file, FIFO pop handshake,
// framing-error bookkeeping, character-timeout timer and RX interrupt.
module rx_uart_ctrl #(
    parameter logic [15:0] TIMEOUT_RESET = 16'd1000,
    parameter int          ERRCNT_WIDTH  = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        bus_valid,
    input  logic [3:0]  bus_wstrb,
    input  logic [1:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    input  logic [31:0] rx_data,
    output logic        rx_rd,
    input  logic        rx_error,
    output logic        irq
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CTRL    = 2'd2;
    localparam logic [1:0] ADDR_TIMEOUT = 2'd3;

    state_t                  r_state;
    logic [31:0]             r_rdata;
    logic                    r_ready;
    logic [2:0]              r_ctrl;
    logic [15:0]             r_timeout;
    logic                    r_err_sticky;
    logic [ERRCNT_WIDTH-1:0] r_errcnt;
    logic [15:0]             r_idle_cnt;
    logic                    r_irq;

    logic        w_avail;
    logic        w_accept;
    logic        w_is_write;
    logic        w_pop;
    logic        w_clear;
    logic        w_timeout_hit;
    logic        w_irq_next;
    logic [31:0] w_status;
    logic [31:0] w_read_mux;

    assign w_avail    = (rx_data != 32'hFFFF_FFFF);
    assign w_accept   = (r_state == IDLE) && bus_valid;
    assign w_is_write = (bus_wstrb != 4'd0);
    // Gated by resetn so a pop coinciding with reset never reaches the FIFO.
    assign w_pop      = resetn && w_accept && !w_is_write &&
                        (bus_addr == ADDR_DATA) && w_avail;
    assign w_clear    = w_accept && w_is_write &&
                        (bus_addr == ADDR_STATUS) && bus_wdata[1];

    assign w_timeout_hit = w_avail && r_ctrl[1] && (r_idle_cnt >= r_timeout);
    assign w_irq_next    = (r_ctrl[0] && w_avail && (!r_ctrl[1] || w_timeout_hit)) ||
                           (r_ctrl[2] && r_err_sticky);

    always_comb begin
        w_status                      = 32'd0;
        w_status[0]                   = w_avail;
        w_status[1]                   = r_err_sticky;
        w_status[2]                   = r_irq;
        w_status[3]                   = w_timeout_hit;
        w_status[8 +: ERRCNT_WIDTH]   = r_errcnt;
    end

    always_comb begin
        w_read_mux = 32'd0;
        case (bus_addr)
            ADDR_DATA:    w_read_mux = rx_data;
            ADDR_STATUS:  w_read_mux = w_status;
            ADDR_CTRL:    w_read_mux = {29'd0, r_ctrl};
            ADDR_TIMEOUT: w_read_mux = {16'd0, r_timeout};
            default:      w_read_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b0;
                    if (bus_valid) begin
                        r_state <= RESP;
                        r_ready <= 1'b1;
                        r_rdata <= w_is_write ? 32'd0 : w_read_mux;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ctrl    <= 3'd0;
            r_timeout <= TIMEOUT_RESET;
        end else if (w_accept && w_is_write) begin
            if (bus_addr == ADDR_CTRL) begin
                r_ctrl <= bus_wdata[2:0];
            end
            if (bus_addr == ADDR_TIMEOUT) begin
                r_timeout <= bus_wdata[15:0];
            end
        end
    end

    // A new error in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_err_sticky <= 1'b0;
            r_errcnt     <= '0;
        end else if (rx_error) begin
            r_err_sticky <= 1'b1;
            if (w_clear) begin
                r_errcnt <= ERRCNT_WIDTH'(1);
            end else if (r_errcnt != {ERRCNT_WIDTH{1'b1}}) begin
                r_errcnt <= r_errcnt + ERRCNT_WIDTH'(1);
            end
        end else if (w_clear) begin
            r_err_sticky <= 1'b0;
            r_errcnt     <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_idle_cnt <= 16'd0;
        end else if (!w_avail || w_pop || !r_ctrl[1]) begin
            r_idle_cnt <= 16'd0;
        end else if (r_idle_cnt != 16'hFFFF) begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= w_irq_next;
        end
    end

    assign bus_rdata = r_rdata;
    assign bus_ready = r_ready;
    assign rx_rd     = w_pop;
    assign irq       = r_irq;

endmodule

// File: tb/tb_rx_uart_ctrl.sv
// Directed bench for rx_uart_ctrl: register table, pop handshake, timeout irq,
// error counter saturation/clear, back-to-back reads and mid-access reset.
module tb_rx_uart_ctrl;

    logic        clk;
    logic        resetn;
    logic        bus_valid;
    logic [3:0]  bus_wstrb;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic [31:0] rx_data;
    logic        rx_rd;
    logic        rx_error;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Receive FIFO model: head word is all-ones when empty.
    logic [7:0] fifo_mem [0:15];
    int         fifo_wr = 0;
    int         fifo_rd = 0;
    int         pop_total = 0;

    assign rx_data = (fifo_wr != fifo_rd) ? {24'd0, fifo_mem[fifo_rd[3:0]]} : 32'hFFFF_FFFF;

    always @(posedge clk) begin
        if (rx_rd) begin
            fifo_rd   <= fifo_rd + 1;
            pop_total <= pop_total + 1;
        end
    end

    rx_uart_ctrl #(
        .TIMEOUT_RESET(16'd1000),
        .ERRCNT_WIDTH (8)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus_valid(bus_valid),
        .bus_wstrb(bus_wstrb),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ready(bus_ready),
        .rx_data  (rx_data),
        .rx_rd    (rx_rd),
        .rx_error (rx_error),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[fifo_wr[3:0]] = b;
        fifo_wr = fifo_wr + 1;
    endtask

    task automatic bus_xfer(input logic wr, input logic [1:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int cycles, output int pops);
        bit done;
        done   = 1'b0;
        rdata  = 32'd0;
        cycles = 0;
        pops   = 0;
        @(negedge clk);
        bus_valid = 1'b1;
        bus_wstrb = wr ? 4'hF : 4'h0;
        bus_addr  = addr;
        bus_wdata = wdata;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            cycles++;
            if (rx_rd) pops++;
            if (bus_ready) begin
                rdata = bus_rdata;
                done  = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        bus_valid = 1'b0;
        bus_wstrb = 4'h0;
        if (!done) check("bus_ready_timeout", 32'd0, 32'd1);
        $display("txn %s addr=%0d wdata=%h rdata=%h cycles=%0d pops=%0d",
                 wr ? "WR" : "RD", addr, wdata, rdata, cycles, pops);
    endtask

    task automatic do_read(input string name, input logic [1:0] addr,
                           input logic [31:0] exp, input int exp_pops);
        logic [31:0] rd;
        int cyc, pp;
        bus_xfer(1'b0, addr, 32'd0, rd, cyc, pp);
        check({name, "_rdata"}, rd, exp);
        check({name, "_cycles"}, 32'(cyc), 32'd2);
        check({name, "_pops"}, 32'(pp), 32'(exp_pops));
    endtask

    task automatic do_write(input string name, input logic [1:0] addr, input logic [31:0] wdata);
        logic [31:0] rd;
        int cyc, pp;
        bus_xfer(1'b1, addr, wdata, rd, cyc, pp);
        check({name, "_cycles"}, 32'(cyc), 32'd2);
        check({name, "_pops"}, 32'(pp), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b2b_exp [4];
        int          start_pops;
        int          rr;
        int          nready;

        resetn    = 1'b0;
        bus_valid = 1'b0;
        bus_wstrb = 4'h0;
        bus_addr  = 2'd0;
        bus_wdata = 32'd0;
        rx_error  = 1'b0;

        vecs[0]  = '{1'b0, 2'd1, 32'd0,          32'h0000_0000, "rst_status"};
        vecs[1]  = '{1'b0, 2'd3, 32'd0,          32'd1000,      "rst_timeout"};
        vecs[2]  = '{1'b0, 2'd2, 32'd0,          32'h0000_0000, "rst_ctrl"};
        vecs[3]  = '{1'b0, 2'd0, 32'd0,          32'hFFFF_FFFF, "empty_data"};
        vecs[4]  = '{1'b1, 2'd2, 32'hFFFF_FFF5,  32'd0,         "wr_ctrl"};
        vecs[5]  = '{1'b0, 2'd2, 32'd0,          32'h0000_0005, "rd_ctrl"};
        vecs[6]  = '{1'b1, 2'd3, 32'hABCD_1234,  32'd0,         "wr_timeout"};
        vecs[7]  = '{1'b0, 2'd3, 32'd0,          32'h0000_1234, "rd_timeout"};
        vecs[8]  = '{1'b1, 2'd0, 32'h0000_0077,  32'd0,         "wr_data"};
        vecs[9]  = '{1'b0, 2'd1, 32'd0,          32'h0000_0000, "status_idle"};
        vecs[10] = '{1'b1, 2'd2, 32'h0000_0000,  32'd0,         "wr_ctrl0"};
        vecs[11] = '{1'b0, 2'd2, 32'd0,          32'h0000_0000, "rd_ctrl0"};

        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", {31'd0, bus_ready}, 32'd0);
        check("rst_rdata", bus_rdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) do_write(vecs[i].name, vecs[i].addr, vecs[i].wdata);
            else            do_read(vecs[i].name, vecs[i].addr, vecs[i].exp, 0);
        end
        check("no_pop_so_far", 32'(pop_total), 32'd0);

        // Single byte pop, then empty read.
        push(8'h41);
        do_read("data_41", 2'd0, 32'h0000_0041, 1);
        do_read("data_empty", 2'd0, 32'hFFFF_FFFF, 0);

        // Timeout interrupt: CTRL=3, TIMEOUT=5.
        do_write("ctrl3", 2'd2, 32'd3);
        do_write("tmo5", 2'd3, 32'd5);
        @(negedge clk);
        push(8'h5A);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            #1;
            if (i == 5) check("tmo_irq_c5", {31'd0, irq}, 32'd0);
            if (i == 6) check("tmo_irq_c6", {31'd0, irq}, 32'd1);
        end
        do_read("tmo_status", 2'd1, 32'h0000_000D, 0);
        do_read("tmo_pop", 2'd0, 32'h0000_005A, 1);
        @(negedge clk);
        #1;
        check("tmo_irq_cleared", {31'd0, irq}, 32'd0);

        // timeout_en=0: irq one cycle after avail.
        do_write("ctrl1", 2'd2, 32'd1);
        @(negedge clk);
        push(8'h33);
        #1;
        check("noto_irq_c0", {31'd0, irq}, 32'd0);
        @(negedge clk);
        #1;
        check("noto_irq_c1", {31'd0, irq}, 32'd1);
        do_read("noto_pop", 2'd0, 32'h0000_0033, 1);

        // Error counter saturation and clears.
        do_write("ctrl0b", 2'd2, 32'd0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            rx_error = 1'b1;
            @(negedge clk);
            rx_error = 1'b0;
        end
        do_read("err_sat_status", 2'd1, 32'h0000_FF02, 0);
        do_write("ctrl4", 2'd2, 32'd4);
        @(negedge clk);
        #1;
        check("err_irq", {31'd0, irq}, 32'd1);
        @(negedge clk);
        bus_valid = 1'b1;
        bus_wstrb = 4'hF;
        bus_addr  = 2'd1;
        bus_wdata = 32'h0000_0002;
        rx_error  = 1'b1;
        @(negedge clk);
        rx_error = 1'b0;
        #1;
        check("clr_err_ready", {31'd0, bus_ready}, 32'd1);
        bus_valid = 1'b0;
        bus_wstrb = 4'h0;
        $display("txn WR addr=1 wdata=00000002 with coincident rx_error");
        do_read("clr_vs_err_status", 2'd1, 32'h0000_0106, 0);
        do_write("clr_plain", 2'd1, 32'h0000_0002);
        do_read("clr_status", 2'd1, 32'h0000_0000, 0);
        do_write("ctrl0c", 2'd2, 32'd0);

        // Back-to-back DATA reads with bus_valid held.
        b2b_exp[0] = 32'h10;
        b2b_exp[1] = 32'h11;
        b2b_exp[2] = 32'h12;
        b2b_exp[3] = 32'hFFFF_FFFF;
        start_pops = pop_total;
        rr = 0;
        nready = 0;
        @(negedge clk);
        push(8'h10);
        push(8'h11);
        push(8'h12);
        bus_valid = 1'b1;
        bus_wstrb = 4'h0;
        bus_addr  = 2'd0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            #1;
            if (rx_rd) rr++;
            if (bus_ready) begin
                if (nready < 4) begin
                    check("b2b_rdata", bus_rdata, b2b_exp[nready]);
                    check("b2b_cycle", 32'(cyc), 32'(2 * (nready + 1)));
                end
                $display("txn RD addr=0 b2b rdata=%h cycle=%0d", bus_rdata, cyc);
                nready++;
            end
            if (cyc < 8) @(negedge clk);
        end
        bus_valid = 1'b0;
        check("b2b_pops", 32'(rr), 32'd3);
        check("b2b_ready_count", 32'(nready), 32'd4);
        @(negedge clk);
        check("b2b_pop_total", 32'(pop_total - start_pops), 32'd3);

        // Reset asserted in the accept cycle squashes the pop.
        start_pops = pop_total;
        push(8'h55);
        bus_valid = 1'b1;
        bus_wstrb = 4'h0;
        bus_addr  = 2'd0;
        resetn    = 1'b0;
        #1;
        check("rst_squash_rd", {31'd0, rx_rd}, 32'd0);
        @(negedge clk);
        resetn    = 1'b1;
        bus_valid = 1'b0;
        #1;
        check("rst_squash_ready", {31'd0, bus_ready}, 32'd0);
        check("rst_squash_pops", 32'(pop_total - start_pops), 32'd0);
        do_read("after_rst_data", 2'd0, 32'h0000_0055, 1);

        // Reset during the response cycle.
        do_write("tmo7", 2'd3, 32'd7);
        @(negedge clk);
        bus_valid = 1'b1;
        bus_wstrb = 4'h0;
        bus_addr  = 2'd3;
        @(negedge clk);
        #1;
        check("resp_ready", {31'd0, bus_ready}, 32'd1);
        check("resp_rdata", bus_rdata, 32'd7);
        resetn    = 1'b0;
        bus_valid = 1'b0;
        @(negedge clk);
        #1;
        check("resp_rst_ready", {31'd0, bus_ready}, 32'd0);
        resetn = 1'b1;
        do_read("resp_rst_timeout", 2'd3, 32'd1000, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_uart_ctrl.md
# rx_uart_ctrl

Memory-mapped controller that sequences the UART receive path for the CPU. It sits between the SoC bus (valid/ready handshake) and the receive core (FIFO head word, pop strobe, framing-error pulse). It owns the pop handshake, the sticky error/status bookkeeping, the character-timeout timer and the RX interrupt line.

## Interface
- TIMEOUT_RESET, 16'd1000: reset value of the TIMEOUT register (idle clk cycles).
- ERRCNT_WIDTH, 8: width of the saturating framing-error counter (1..8).
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- bus_valid  in  1  access request; held until bus_ready.
- bus_wstrb  in  4  nonzero = write, zero = read.
- bus_addr  in  2  word select: 0 DATA, 1 STATUS, 2 CTRL, 3 TIMEOUT.
- bus_wdata  in  32  write data.
- bus_rdata  out  32  read data, valid while bus_ready=1.
- bus_ready  out  1  one-cycle completion pulse.
- rx_data  in  32  receive FIFO head; 32'hFFFF_FFFF means empty, else {24'd0, byte}.
- rx_rd  out  1  one-cycle pop strobe to the receive FIFO.
- rx_error  in  1  framing-error indication from the receive core (one cycle per event).
- irq  out  1  registered level interrupt.

## Operation
- avail = (rx_data != 32'hFFFF_FFFF), combinational.
- FSM: IDLE, RESP. IDLE with bus_valid=1: perform the access and go to RESP. RESP: bus_ready=1 for one cycle, then go to IDLE. Every access completes in exactly 2 cycles. At most one pop per access.
- DATA read: rdata <= rx_data. If avail, rx_rd=1 for that one IDLE cycle; if empty, return 32'hFFFF_FFFF and do not pop. DATA write: acknowledged, ignored.
- STATUS read, no side effects: [0] avail, [1] err_sticky, [2] irq, [3] timeout_hit, [8+:ERRCNT_WIDTH] errcnt, other bits 0.
- STATUS write: wdata[1]=1 clears err_sticky and errcnt. Other bits are ignored.
- CTRL (R/W, bits [2:0]): [0] rx_irq_en, [1] timeout_en, [2] err_irq_en. Other bits read 0.
- TIMEOUT (R/W, bits [15:0]): threshold. Other bits read 0.
- Error tracking:
  - rx_error=1: err_sticky <= 1; errcnt increments, saturating at all-ones.
  - rx_error in the same cycle as a clear write: error wins. err_sticky=1, errcnt=1.
- Idle counter (16 bit):
  - Cleared when !avail, when rx_rd=1, or when timeout_en=0.
  - Otherwise increments by 1 per cycle, saturating at 16'hFFFF.
  - timeout_hit = (counter >= TIMEOUT). TIMEOUT=0 gives timeout_hit=1 whenever avail and timeout_en=1.
- irq_next = (rx_irq_en & avail & (!timeout_en | timeout_hit)) | (err_irq_en & err_sticky).
  - irq is registered: it follows irq_next with 1-cycle latency.

## Timing
- Reset values: bus_ready 0, bus_rdata 0, rx_rd 0, irq 0, state IDLE, CTRL 0, TIMEOUT TIMEOUT_RESET, err_sticky 0, errcnt 0, counter 0.
- Read: accept at edge N (IDLE, rx_rd asserted during cycle N when popping). bus_ready=1 and rdata valid during cycle N+1.
- The FIFO head is allowed two edges to settle after a pop before the next DATA read samples it.
- Register writes take effect at the accept edge. A read in the following access returns the new value.
- bus_valid low in IDLE: no state change, rx_rd=0.
- Reset mid-access: the FSM returns to IDLE and bus_ready drops the next cycle. An in-flight pop strobe is squashed if reset is low in that cycle.
- irq lags its cause by 1 cycle. It deasserts 1 cycle after the clearing event (pop emptying the FIFO, clear write, or enable cleared).

## Test plan
- Reset, then read STATUS -> 32'h0. Read TIMEOUT -> 1000. rx_rd never asserted.
- rx_data=32'h41, then DATA read -> rx_rd pulses once, bus_rdata=32'h41 with bus_ready. With rx_data=32'hFFFF_FFFF, DATA read -> 32'hFFFF_FFFF and no rx_rd.
- CTRL=3, TIMEOUT=5, one byte present -> irq rises exactly 6 cycles after avail rises, STATUS[3]=1. A DATA read that empties the FIFO -> irq low 1 cycle after rx_rd.
- CTRL=1 (timeout_en=0), byte present -> irq 1 cycle after avail.
- 300 rx_error pulses (ERRCNT_WIDTH=8) -> STATUS[15:8]=8'hFF, STATUS[1]=1. With CTRL=4 -> irq=1. Write STATUS 32'h2 coincident with an rx_error pulse -> errcnt=1, err_sticky=1.
- Back-to-back DATA reads with bus_valid held high across 3 FIFO bytes (0x10, 0x11, 0x12) -> rdata sequence 0x10, 0x11, 0x12, then 0xFFFF_FFFF; exactly 3 rx_rd pulses, each access exactly 2 cycles.
